// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NS    = WIDTH / NIB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed clamp values for the default datapath width.
  localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/nibble_cla.sv
// Combinational 4-bit carry-lookahead adder slice.
// Exposes the carry into bit 3 so the parent can derive signed overflow.
module nibble_cla
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms with every carry expanded directly from ci.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    c3   = c[3];
    co   = c[4];
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-cycle add/subtract unit: one nibble per cycle, LSB nibble first,
// with a registered carry between nibbles and optional signed saturation.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NSL = WIDTH / NIB;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);
  localparam logic [WIDTH-1:0] CLAMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] CLAMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [NIB-1:0]   slice_a;
  logic [NIB-1:0]   slice_b;
  logic [NIB-1:0]   slice_s;
  logic             slice_c3;
  logic             slice_co;
  logic             ovfl_now;
  logic [WIDTH-1:0] final_val;

  // Select the current nibble; B is inverted here for subtract.
  always_comb begin
    slice_a = a_q[idx_q*NIB +: NIB];
    slice_b = b_q[idx_q*NIB +: NIB] ^ {NIB{sub_q}};
  end

  nibble_cla u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .co (slice_co)
  );

  // Next-state, datapath and flag computation for the whole unit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    sat_d     = sat_q;
    acc_d     = acc_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;
    cout_d    = cout_q;
    ovfl_d    = ovfl_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovfl_now  = slice_c3 ^ slice_co;
    final_val = acc_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          sat_d   = sat;
          carry_d = cin | sub;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_q*NIB +: NIB] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        busy_d  = 1'b1;
        if (idx_q == LAST_IDX) begin
          final_val = acc_d;
          if (sat_q && ovfl_now) begin
            final_val = a_q[WIDTH-1] ? CLAMP_MIN : CLAMP_MAX;
          end
          result_d = final_val;
          cout_d   = slice_co;
          ovfl_d   = ovfl_now;
          zero_d   = (final_val == '0);
          neg_d    = final_val[WIDTH-1];
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      sat_q    <= 1'b0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      sat_q    <= sat_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovfl_q   <= ovfl_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovfl   = ovfl_q;
  assign zero   = zero_q;
  assign neg    = neg_q;

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Multi-cycle 16-bit add/subtract unit with optional signed saturation.
- Processes one 4-bit nibble per cycle, LSB nibble first, through a single nibble carry-lookahead slice.
- A registered carry links consecutive nibbles.
- Sits upstream of the ALU result mux and flag register; trades latency for area in the low-cost datapath configuration.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4.
- NIB, 4, slice width; fixed. Number of slices NS = WIDTH/NIB.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- sub  input  1  1 = A-B (B inverted, carry-in forced 1); captured.
- sat  input  1  1 = clamp signed overflow; captured.
- busy  output  1  high while operation in flight (RUN state).
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  final result; held until next accepted start's done.
- cout  output  1  carry out of MSB, raw (before saturation).
- ovfl  output  1  signed overflow.
- zero  output  1  result == 0 (after saturation).
- neg  output  1  result[WIDTH-1] (after saturation).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovfl=0, zero=0, neg=0.
  - Nibble index, carry register and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b, cin, sub, sat.
  - Sets carry_reg = cin | sub and idx=0, then goes to RUN.
- RUN, each edge:
  - The slice adds A[idx] with (sub ? ~B : B)[idx] and carry_reg.
  - Writes the sum nibble into an internal accumulator at idx, updates carry_reg to the slice carry-out, and increments idx.
  - On the edge with idx = NS-1:
    - Latch cout = slice carry-out.
    - Latch ovfl = slice carry into bit 3 XOR slice carry-out.
    - Compute final result; transition to DONE.
- Saturation (applied on the last RUN edge):
  - If sat=1 and ovfl=1: result = A[WIDTH-1] ? 0x8000 : 0x7FFF (for WIDTH=16; generally min/max signed). The sign of A alone gives the overflow direction for both add and subtract.
  - Otherwise result = accumulator.
  - cout and ovfl report the unsaturated operation.
- Flags: zero and neg are computed from the final (saturated) result and are registered together with it.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Latency:
  - start high in cycle 0 → busy in cycles 1..NS → done in cycle NS+1 (cycle 5 for WIDTH=16).
  - Throughput: one operation per NS+1 cycles.
- start while busy=1 is ignored; operand inputs may change freely while busy.
- result, cout, ovfl, zero and neg change only on the DONE-entry edge or on reset. Between operations they hold their last values.
- rst mid-operation:
  - Operation is aborted; no done pulse is produced.
  - All outputs return to their reset values on that edge.
- Simultaneous rst and start: rst wins; start is dropped.

Decomposition:
- Shared package (alu_pkg):
  - WIDTH and NIB constants.
  - State enum {IDLE, RUN, DONE}.
  - Saturation constants SAT_MAX = 0x7FFF and SAT_MIN = 0x8000.
- Sub-module nibble_cla:
  - Combinational 4-bit carry-lookahead slice.
  - Inputs a[3:0], b[3:0], ci. Outputs s[3:0], c3 (carry into bit 3), co.
  - Operand inversion for subtract is done in the parent before the slice.
- Parent contains the FSM, nibble index counter, carry register, operand and accumulator registers, and the saturation/flag logic.

Test Plan:
- Add: a=0x1234, b=0x0F0F, sub=0, sat=0, start for 1 cycle → done in cycle 5; result=0x2143, cout=0, ovfl=0, zero=0, neg=0.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0.
  - sat=0 → result=0x8000, ovfl=1, neg=1.
  - sat=1 → result=0x7FFF, ovfl=1, neg=0, cout=0.
- Negative overflow subtract: a=0x8000, b=0x0001, sub=1, sat=1 → result=0x8000, ovfl=1, cout=1, neg=1.
- Zero and back-to-back:
  - a=0x0005, b=0x0005, sub=1 → result=0x0000, zero=1, cout=1.
  - start held high in the DONE cycle with a=0xFFFF, b=0x0001, sub=0 → second done exactly 5 cycles later; result=0x0000, cout=1, ovfl=0.
- Busy-ignore: assert start again in cycles 2 and 3 with different operands → only one done pulse; result matches the first operands; busy high in cycles 1..4 only.
- Reset mid-op: start in cycle 0, rst=1 in cycle 2 → in cycle 3 busy=0, done=0, result=0; no done pulse in cycles 3..8; a new start after reset completes normally.
